// File: rtl/micro_sequencer.sv
// Next-state logic for the microprogrammed control unit.
// Selects the next ROM address from incr / encoder / CR under a
// condition mux, and keeps a small LIFO of return addresses for
// microsubroutine call/return. STACK_DEPTH must be a power of two, 2..8.
module micro_sequencer #(
    parameter int         STACK_DEPTH = 4,
    parameter logic [7:0] FETCH_STATE = 8'd1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] n_sel,
    input  logic       inv,
    input  logic [2:0] cond_sel,
    input  logic [7:0] cr,
    input  logic [7:0] enc_state,
    input  logic       mfa,
    input  logic       cond_pass,
    input  logic       ir_l,
    input  logic       ir_s,
    input  logic       cnt_zero,
    input  logic       irq,
    output logic [7:0] state,
    output logic       stack_err
);

    localparam int IW  = $clog2(STACK_DEPTH);
    localparam int SPW = IW + 1;

    typedef enum logic [2:0] {
        N_INCR    = 3'b000,
        N_ENC     = 3'b001,
        N_CR      = 3'b010,
        N_CR_INC  = 3'b011,
        N_CR_ENC  = 3'b100,
        N_ENC_INC = 3'b101,
        N_CALL    = 3'b110,
        N_RET     = 3'b111
    } nsel_e;

    typedef enum logic [2:0] {
        C_MFA   = 3'b000,
        C_PASS  = 3'b001,
        C_IRL   = 3'b010,
        C_IRS   = 3'b011,
        C_CZERO = 3'b100,
        C_IRQ   = 3'b101,
        C_ZERO  = 3'b110,
        C_ONE   = 3'b111
    } csel_e;

    logic [7:0]     stk [STACK_DEPTH];
    logic [SPW-1:0] sp;
    logic [SPW-1:0] sp_m1;
    logic [IW-1:0]  wr_idx;
    logic [IW-1:0]  rd_idx;
    logic [7:0]     incr;
    logic [7:0]     top;
    logic [7:0]     next_state;
    logic           raw;
    logic           c;
    logic           full;
    logic           empty;
    logic           is_call;
    logic           is_ret;
    logic           push_ok;
    logic           pop_ok;
    logic           err_ev;

    assign incr    = state + 8'd1;
    assign full    = (sp == SPW'(STACK_DEPTH));
    assign empty   = (sp == '0);
    assign sp_m1   = sp - SPW'(1);
    assign wr_idx  = sp[IW-1:0];
    assign rd_idx  = sp_m1[IW-1:0];
    assign top     = stk[rd_idx];
    assign is_call = (n_sel == N_CALL);
    assign is_ret  = (n_sel == N_RET);
    // A push into a full stack is dropped; a pop from empty redirects to fetch.
    assign push_ok = is_call && !full;
    assign pop_ok  = is_ret && !empty;
    assign err_ev  = (is_call && full) || (is_ret && empty);
    assign c       = raw ^ inv;

    // Condition mux over the status inputs.
    always_comb begin
        raw = 1'b0;
        case (csel_e'(cond_sel))
            C_MFA:   raw = mfa;
            C_PASS:  raw = cond_pass;
            C_IRL:   raw = ir_l;
            C_IRS:   raw = ir_s;
            C_CZERO: raw = cnt_zero;
            C_IRQ:   raw = irq;
            C_ZERO:  raw = 1'b0;
            C_ONE:   raw = 1'b1;
            default: raw = 1'b0;
        endcase
    end

    // Next-address select.
    always_comb begin
        next_state = incr;
        case (nsel_e'(n_sel))
            N_INCR:    next_state = incr;
            N_ENC:     next_state = enc_state;
            N_CR:      next_state = cr;
            N_CR_INC:  next_state = c ? cr : incr;
            N_CR_ENC:  next_state = c ? cr : enc_state;
            N_ENC_INC: next_state = c ? enc_state : incr;
            N_CALL:    next_state = cr;
            N_RET:     next_state = empty ? FETCH_STATE : top;
            default:   next_state = incr;
        endcase
    end

    // State register, return stack and sticky error flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= 8'd0;
            sp        <= '0;
            stack_err <= 1'b0;
            for (int i = 0; i < STACK_DEPTH; i++) stk[i] <= 8'd0;
        end else begin
            state <= next_state;
            if (push_ok) begin
                stk[wr_idx] <= incr;
                sp          <= sp + SPW'(1);
            end
            if (pop_ok) sp <= sp_m1;
            if (err_ev) stack_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_micro_sequencer.sv
// Bench for micro_sequencer: a directed vector table with constant
// expectations, then a random phase checked against a behavioural model.
// Expected results go through a queue and are popped after each edge.
module tb_micro_sequencer;

    typedef struct {
        logic       rst;
        logic [2:0] n;
        logic       iv;
        logic [2:0] cs;
        logic [7:0] cr;
        logic [7:0] enc;
        logic [5:0] st;   // {irq, cnt_zero, ir_s, ir_l, cond_pass, mfa}
        logic [7:0] es;
        logic       ee;
    } vec_t;

    typedef struct {
        logic [7:0] s;
        logic       e;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [2:0] n_sel = '0;
    logic       inv = 1'b0;
    logic [2:0] cond_sel = '0;
    logic [7:0] cr = '0;
    logic [7:0] enc_state = '0;
    logic       mfa = 1'b0, cond_pass = 1'b0, ir_l = 1'b0, ir_s = 1'b0;
    logic       cnt_zero = 1'b0, irq = 1'b0;
    logic [7:0] state;
    logic       stack_err;

    int n_tests = 0;
    int n_fail  = 0;
    exp_t expq[$];

    micro_sequencer #(.STACK_DEPTH(4), .FETCH_STATE(8'd1)) dut (
        .clk(clk), .reset(reset), .n_sel(n_sel), .inv(inv), .cond_sel(cond_sel),
        .cr(cr), .enc_state(enc_state), .mfa(mfa), .cond_pass(cond_pass),
        .ir_l(ir_l), .ir_s(ir_s), .cnt_zero(cnt_zero), .irq(irq),
        .state(state), .stack_err(stack_err)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(logic rst, logic [2:0] n, logic iv, logic [2:0] cs,
                                logic [7:0] cr_v, logic [7:0] enc, logic [5:0] st,
                                logic [7:0] es, logic ee);
        vec_t v;
        v.rst = rst; v.n = n; v.iv = iv; v.cs = cs; v.cr = cr_v;
        v.enc = enc; v.st = st; v.es = es; v.ee = ee;
        return v;
    endfunction

    // Drive one control word, queue its expectation, compare after the edge.
    task automatic step(input vec_t v, input string tag, input int idx);
        exp_t e;
        exp_t got;
        @(negedge clk);
        reset = v.rst; n_sel = v.n; inv = v.iv; cond_sel = v.cs;
        cr = v.cr; enc_state = v.enc;
        {irq, cnt_zero, ir_s, ir_l, cond_pass, mfa} = v.st;
        e.s = v.es; e.e = v.ee;
        expq.push_back(e);
        @(posedge clk);
        #1;
        got = expq.pop_front();
        n_tests++;
        if (state !== got.s) begin
            n_fail++;
            $display("FAIL %s[%0d] state got %0d want %0d", tag, idx, state, got.s);
        end
        n_tests++;
        if (stack_err !== got.e) begin
            n_fail++;
            $display("FAIL %s[%0d] stack_err got %b want %b", tag, idx, stack_err, got.e);
        end
    endtask

    initial begin
        vec_t tv[$];
        vec_t v;
        logic [7:0] ms;
        logic       me;
        logic [7:0] mstk[$];
        logic [7:0] inc;
        logic       rawc;
        logic       c;

        // reset and increment
        tv.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
        tv.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
        tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0));
        tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 2, 0));
        tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 3, 0));
        // wait on mfa at state 3
        for (int i = 0; i < 4; i++) tv.push_back(mk(0, 3, 1, 0, 3, 0, 6'b000000, 3, 0));
        tv.push_back(mk(0, 3, 1, 0, 3, 0, 6'b000001, 4, 0));
        // each condition source, other sources at the opposite level
        tv.push_back(mk(0, 3, 0, 1, 40, 0, 6'b000010, 40, 0));
        tv.push_back(mk(0, 3, 0, 1, 99, 0, 6'b111101, 41, 0));
        tv.push_back(mk(0, 3, 0, 2, 60, 0, 6'b000100, 60, 0));
        tv.push_back(mk(0, 3, 0, 3, 70, 0, 6'b110111, 61, 0));
        tv.push_back(mk(0, 3, 0, 4, 80, 0, 6'b010000, 80, 0));
        tv.push_back(mk(0, 3, 0, 5, 90, 0, 6'b011111, 81, 0));
        tv.push_back(mk(0, 3, 0, 6, 90, 0, 6'b111111, 82, 0));
        tv.push_back(mk(0, 3, 0, 7, 100, 0, 6'b000000, 100, 0));
        tv.push_back(mk(0, 3, 1, 7, 7, 0, 6'b000000, 101, 0));
        tv.push_back(mk(0, 3, 0, 0, 110, 0, 6'b000001, 110, 0));
        // wrap and encoder
        tv.push_back(mk(0, 2, 0, 0, 255, 0, 0, 255, 0));
        tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        tv.push_back(mk(0, 1, 0, 0, 0, 17, 0, 17, 0));
        // c ? cr : enc, then inverted
        tv.push_back(mk(0, 4, 0, 1, 1, 10, 6'b000000, 10, 0));
        tv.push_back(mk(0, 4, 0, 1, 1, 10, 6'b000010, 1, 0));
        tv.push_back(mk(0, 4, 1, 1, 1, 10, 6'b000000, 1, 0));
        tv.push_back(mk(0, 4, 1, 1, 1, 10, 6'b000010, 10, 0));
        // c ? enc : incr
        tv.push_back(mk(0, 5, 0, 0, 0, 33, 6'b000001, 33, 0));
        tv.push_back(mk(0, 5, 0, 0, 0, 33, 6'b000000, 34, 0));
        // nested call / return, return right after call
        tv.push_back(mk(0, 2, 0, 0, 20, 0, 0, 20, 0));
        tv.push_back(mk(0, 6, 0, 0, 50, 0, 0, 50, 0));
        tv.push_back(mk(0, 6, 0, 0, 60, 0, 0, 60, 0));
        tv.push_back(mk(0, 7, 0, 0, 0, 0, 0, 51, 0));
        tv.push_back(mk(0, 7, 0, 0, 0, 0, 0, 21, 0));
        // overflow: five calls, five returns
        for (int i = 0; i < 4; i++) tv.push_back(mk(0, 6, 0, 0, 8'(100 + i), 0, 0, 8'(100 + i), 0));
        tv.push_back(mk(0, 6, 0, 0, 104, 0, 0, 104, 1));
        tv.push_back(mk(0, 7, 0, 0, 0, 0, 0, 103, 1));
        tv.push_back(mk(0, 7, 0, 0, 0, 0, 0, 102, 1));
        tv.push_back(mk(0, 7, 0, 0, 0, 0, 0, 101, 1));
        tv.push_back(mk(0, 7, 0, 0, 0, 0, 0, 22, 1));
        tv.push_back(mk(0, 7, 0, 0, 0, 0, 0, 1, 1));
        tv.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
        // underflow from fresh reset, then reset mid-call discards stack
        tv.push_back(mk(0, 7, 0, 0, 0, 0, 0, 1, 1));
        tv.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
        tv.push_back(mk(0, 2, 0, 0, 40, 0, 0, 40, 0));
        tv.push_back(mk(0, 6, 0, 0, 50, 0, 0, 50, 0));
        tv.push_back(mk(1, 7, 0, 0, 0, 0, 0, 0, 0));
        tv.push_back(mk(0, 7, 0, 0, 0, 0, 0, 1, 1));
        tv.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0));

        foreach (tv[i]) step(tv[i], "vec", i);

        // random phase against a queue-based model, starting from reset
        ms = 8'd0;
        me = 1'b0;
        for (int i = 0; i < 300; i++) begin
            v.rst = 1'b0;
            v.n   = 3'($urandom_range(0, 7));
            v.iv  = 1'($urandom_range(0, 1));
            v.cs  = 3'($urandom_range(0, 7));
            v.cr  = 8'($urandom_range(0, 255));
            v.enc = 8'($urandom_range(0, 255));
            v.st  = 6'($urandom_range(0, 63));
            if (v.cs == 3'd6)      rawc = 1'b0;
            else if (v.cs == 3'd7) rawc = 1'b1;
            else                   rawc = v.st[int'(v.cs)];
            c   = rawc ^ v.iv;
            inc = ms + 8'd1;
            case (v.n)
                3'd0: ms = inc;
                3'd1: ms = v.enc;
                3'd2: ms = v.cr;
                3'd3: ms = c ? v.cr : inc;
                3'd4: ms = c ? v.cr : v.enc;
                3'd5: ms = c ? v.enc : inc;
                3'd6: begin
                    if (mstk.size() < 4) mstk.push_back(inc);
                    else me = 1'b1;
                    ms = v.cr;
                end
                default: begin
                    if (mstk.size() == 0) begin
                        ms = 8'd1;
                        me = 1'b1;
                    end else begin
                        ms = mstk.pop_back();
                    end
                end
            endcase
            v.es = ms;
            v.ee = me;
            step(v, "rnd", i);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
